inst_fetch: RTL and testbench

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch_pkg.sv | 19 +
 rtl/fetch_fifo.sv | 64 ++++++
 rtl/inst_fetch.sv | 134 +++++++++++++
 tb/tb_inst_fetch.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_pkg.sv
// rtl/inst_fetch_pkg.sv - shared types and constants for the instruction fetch block
package inst_fetch_pkg;

    localparam int INST_BYTES = 4;
    // Buffer entries carry the widest supported PC; the top uses the low ADDR_W bits.
    localparam int MAX_ADDR_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0]           data;
        logic [MAX_ADDR_W-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - DEPTH-entry synchronous instruction buffer with occupancy count
module fetch_fifo
    import inst_fetch_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  fetch_entry_t     push_data,
    input  logic             pop,
    output fetch_entry_t     pop_data,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_W'(DEPTH));
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push && !flush && (!full || pop);
        do_pop   = pop && !flush && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - wavefront instruction fetch: credit-limited reads into an in-order buffer
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int ADDR_W = 48,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc,
    input  logic              active,
    input  logic              barrier,
    input  logic              redirect,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_rsp_valid,
    input  logic [31:0]       mem_rsp_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [31:0]       inst_data,
    output logic [ADDR_W-1:0] inst_pc
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] rsp_pc_q, rsp_pc_d;
    logic [CNT_W-1:0]  outstanding_q, outstanding_d;
    logic [CNT_W-1:0]  discard_q, discard_d;
    logic [CNT_W-1:0]  fifo_count;
    logic [ADDR_W-1:0] pc_aligned;
    logic              flush, req_fire, rsp_live, fifo_push, fifo_pop;
    logic              fifo_empty, fifo_full;
    fetch_entry_t      push_entry, head_entry;
    logic              unused_bits;

    assign pc_aligned  = {pc[ADDR_W-1:2], 2'b00};
    assign flush       = redirect || !active;
    assign unused_bits = ^{head_entry.pc, pc[1:0]};

    // Credits cover both in-flight reads and buffered entries, so a response always finds room.
    assign mem_req_valid = (state_q == ST_RUN) && (discard_q == '0) &&
                           (int'(outstanding_q) + int'(fifo_count) < DEPTH);
    assign mem_req_addr  = fetch_pc_q;
    assign req_fire      = mem_req_valid && mem_req_ready;
    assign rsp_live      = mem_rsp_valid && (discard_q == '0);
    assign fifo_push     = rsp_live && !flush;
    assign fifo_pop      = inst_valid && inst_ready;

    assign inst_valid = !fifo_empty;
    assign inst_data  = fifo_empty ? '0 : head_entry.data;
    assign inst_pc    = fifo_empty ? '0 : head_entry.pc[ADDR_W-1:0];

    always_comb begin
        push_entry                 = '0;
        push_entry.data            = mem_rsp_data;
        push_entry.pc[ADDR_W-1:0]  = rsp_pc_q;
    end

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        if (req_fire) begin
            fetch_pc_d    = fetch_pc_q + ADDR_W'(INST_BYTES);
            outstanding_d = outstanding_d + CNT_W'(1);
        end
        if (mem_rsp_valid) begin
            if (discard_q != '0) begin
                discard_d = discard_q - CNT_W'(1);
            end else begin
                outstanding_d = outstanding_d - CNT_W'(1);
                rsp_pc_d      = rsp_pc_q + ADDR_W'(INST_BYTES);
            end
        end
        // Everything still in flight, including a read accepted this cycle, becomes stale.
        if (flush) begin
            fetch_pc_d    = pc_aligned;
            rsp_pc_d      = pc_aligned;
            discard_d     = discard_d + outstanding_d;
            outstanding_d = '0;
        end
        if (!active) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d    = ST_RUN;
                    fetch_pc_d = pc_aligned;
                    rsp_pc_d   = pc_aligned;
                end
                ST_RUN:  if (barrier)  state_d = ST_HOLD;
                ST_HOLD: if (!barrier) state_d = ST_RUN;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            fetch_pc_q    <= '0;
            rsp_pc_q      <= '0;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .pop_data  (head_entry),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assert property (@(posedge clk) disable iff (reset) !(rsp_live && fifo_full));

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - directed self-checking bench for inst_fetch with a 1-cycle memory model
module tb_inst_fetch;

    localparam int ADDR_W = 48;
    localparam int DEPTH  = 4;

    logic              clk;
    logic              reset;
    logic [ADDR_W-1:0] pc;
    logic              active, barrier, redirect;
    logic              mem_req_valid, mem_req_ready;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_rsp_valid;
    logic [31:0]       mem_rsp_data;
    logic              inst_valid, inst_ready;
    logic [31:0]       inst_data;
    logic [ADDR_W-1:0] inst_pc;

    inst_fetch #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .pc            (pc),
        .active        (active),
        .barrier       (barrier),
        .redirect      (redirect),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .inst_data     (inst_data),
        .inst_pc       (inst_pc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [ADDR_W-1:0] pc_in;
        logic [ADDR_W-1:0] exp_a0;
        logic [ADDR_W-1:0] exp_a1;
        logic [ADDR_W-1:0] exp_a2;
    } vec_t;

    int                n_checks;
    int                n_pass;
    logic [ADDR_W-1:0] pend[$];
    logic [63:0]       req_log[$];
    logic [63:0]       pop_log[$];
    int                rsp_at_fire[$];
    int                rsp_seen;
    int                rsp_limit;
    int                max_out;

    function automatic logic [31:0] dat(input logic [ADDR_W-1:0] a);
        return a[31:0] ^ {a[47:32], 16'h5A5A} ^ 32'hC0DE_0000;
    endfunction

    function automatic logic [63:0] qat(input logic [63:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return '1;
    endfunction

    function automatic int iat(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // One clock: sample handshakes at negedge, then model memory after the edge.
    task automatic cycle();
        logic              fire;
        logic [ADDR_W-1:0] fa;
        int                outs;
        @(negedge clk);
        fire = mem_req_valid && mem_req_ready;
        fa   = mem_req_addr;
        if (inst_valid && inst_ready) begin
            pop_log.push_back(64'(inst_pc));
            chk("inst_data", 64'(inst_data), 64'(dat(inst_pc)));
        end
        @(posedge clk);
        #1;
        if (fire) begin
            pend.push_back(fa);
            req_log.push_back(64'(fa));
            rsp_at_fire.push_back(rsp_seen);
        end
        if (pend.size() > 0 && rsp_seen < rsp_limit) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = dat(pend.pop_front());
            rsp_seen++;
        end else begin
            mem_rsp_valid = 1'b0;
            mem_rsp_data  = '0;
        end
        outs = pend.size() + (mem_rsp_valid ? 1 : 0);
        if (outs > max_out) max_out = outs;
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        active        = 1'b0;
        barrier       = 1'b0;
        redirect      = 1'b0;
        pc            = '0;
        mem_req_ready = 1'b1;
        inst_ready    = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        pend.delete();
        req_log.delete();
        pop_log.delete();
        rsp_at_fire.delete();
        rsp_seen  = 0;
        rsp_limit = 1_000_000;
        max_out   = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_req_valid"},  64'(mem_req_valid), 64'd0);
        chk({tag, "_req_addr"},   64'(mem_req_addr),  64'd0);
        chk({tag, "_inst_valid"}, 64'(inst_valid),    64'd0);
        chk({tag, "_inst_data"},  64'(inst_data),     64'd0);
        chk({tag, "_inst_pc"},    64'(inst_pc),       64'd0);
    endtask

    vec_t tbl[4];

    initial begin
        int n0;
        n_checks = 0;
        n_pass   = 0;

        tbl[0] = '{48'h0000_0000_1000, 48'h0000_0000_1000, 48'h0000_0000_1004, 48'h0000_0000_1008};
        tbl[1] = '{48'h0000_0000_1003, 48'h0000_0000_1000, 48'h0000_0000_1004, 48'h0000_0000_1008};
        tbl[2] = '{48'hFFFF_FFFF_FFFC, 48'hFFFF_FFFF_FFFC, 48'h0000_0000_0000, 48'h0000_0000_0004};
        tbl[3] = '{48'h8000_0000_0006, 48'h8000_0000_0004, 48'h8000_0000_0008, 48'h8000_0000_000C};

        // Reset takes effect before any clock edge.
        reset = 1'b1; active = 1'b0; barrier = 1'b0; redirect = 1'b0; pc = '0;
        mem_req_ready = 1'b1; inst_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
        #1;
        chk_outputs_zero("por");
        do_reset();
        cycle();
        chk_outputs_zero("idle");

        // Alignment and wrap vectors: first three request addresses, first popped pc.
        for (int v = 0; v < 4; v++) begin
            do_reset();
            pc = tbl[v].pc_in;
            active = 1'b1;
            inst_ready = 1'b1;
            repeat (8) cycle();
            chk($sformatf("vec%0d_a0", v), qat(req_log, 0), 64'(tbl[v].exp_a0));
            chk($sformatf("vec%0d_a1", v), qat(req_log, 1), 64'(tbl[v].exp_a1));
            chk($sformatf("vec%0d_a2", v), qat(req_log, 2), 64'(tbl[v].exp_a2));
            chk($sformatf("vec%0d_pop0", v), qat(pop_log, 0), 64'(tbl[v].exp_a0));
        end

        // Streaming from 0x1000 with 1-cycle memory latency.
        do_reset();
        pc = 48'h1000; active = 1'b1; inst_ready = 1'b1;
        cycle();
        chk("run_req_valid", 64'(mem_req_valid), 64'd1);
        chk("run_req_addr", 64'(mem_req_addr), 64'h1000);
        cycle();
        chk("rsp_cycle_inst_valid", 64'(inst_valid), 64'd0);
        cycle();
        chk("lat1_inst_valid", 64'(inst_valid), 64'd1);
        chk("lat1_inst_pc", 64'(inst_pc), 64'h1000);
        repeat (10) cycle();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("stream_req%0d", i), qat(req_log, i), 64'h1000 + 64'(4 * i));
            chk($sformatf("stream_pop%0d", i), qat(pop_log, i), 64'h1000 + 64'(4 * i));
        end
        chk("max_outstanding_le_depth", 64'(max_out <= DEPTH), 64'd1);

        // Decode stalled: credits run out at exactly DEPTH requests.
        do_reset();
        pc = 48'h1000; active = 1'b1; inst_ready = 1'b0;
        repeat (10) cycle();
        chk("stall_req_count", 64'(req_log.size()), 64'd4);
        chk("stall_req_valid", 64'(mem_req_valid), 64'd0);
        chk("stall_full_no_inflight", 64'(pend.size()), 64'd0);
        chk("stall_head_pc", 64'(inst_pc), 64'h1000);
        inst_ready = 1'b1;
        cycle();
        inst_ready = 1'b0;
        repeat (6) cycle();
        chk("one_pop_one_req", 64'(req_log.size()), 64'd5);
        chk("one_pop_req_addr", qat(req_log, 4), 64'h1010);
        chk("one_pop_req_valid", 64'(mem_req_valid), 64'd0);

        // Redirect with one buffered entry and three reads outstanding.
        do_reset();
        pc = 48'h1000; active = 1'b1; inst_ready = 1'b0; rsp_limit = 1;
        for (int k = 0; k < 20 && req_log.size() < 4; k++) cycle();
        chk("pre_redir_outstanding", 64'(pend.size()), 64'd3);
        chk("pre_redir_inst_valid", 64'(inst_valid), 64'd1);
        pc = 48'h2000; redirect = 1'b1;
        cycle();
        redirect = 1'b0;
        chk("redir_flushed", 64'(inst_valid), 64'd0);
        chk("redir_req_blocked", 64'(mem_req_valid), 64'd0);
        rsp_limit = 1_000_000; inst_ready = 1'b1;
        repeat (12) cycle();
        chk("redir_first_req", qat(req_log, 4), 64'h2000);
        chk("redir_req_after_drop", 64'(iat(rsp_at_fire, 4)), 64'd4);
        chk("redir_first_pop", qat(pop_log, 0), 64'h2000);

        // Barrier mid-stream.
        do_reset();
        pc = 48'h3000; active = 1'b1; inst_ready = 1'b1;
        repeat (6) cycle();
        barrier = 1'b1;
        cycle();
        n0 = req_log.size();
        repeat (8) cycle();
        chk("barrier_no_req", 64'(req_log.size()), 64'(n0));
        chk("barrier_req_valid", 64'(mem_req_valid), 64'd0);
        chk("barrier_drained", 64'(pop_log.size()), 64'(n0));
        chk("barrier_inst_valid", 64'(inst_valid), 64'd0);
        barrier = 1'b0;
        for (int k = 0; k < 10 && req_log.size() <= n0; k++) cycle();
        repeat (4) cycle();
        chk("barrier_resume_req", qat(req_log, n0), 64'h3000 + 64'(4 * n0));
        chk("barrier_resume_pop", qat(pop_log, n0), 64'h3000 + 64'(4 * n0));

        // Asynchronous reset mid-burst.
        do_reset();
        pc = 48'hFFFF_FFFF_FFF0; active = 1'b1; inst_ready = 1'b0;
        repeat (4) cycle();
        chk("burst_req_valid", 64'(mem_req_valid), 64'd1);
        chk("burst_inst_valid", 64'(inst_valid), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        chk_outputs_zero("async");
        pend.delete();
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("post_reset_idle", 64'(mem_req_valid), 64'd0);
        cycle();
        chk("post_reset_run", 64'(mem_req_valid), 64'd1);
        chk("post_reset_addr", 64'(mem_req_addr), 64'hFFFF_FFFF_FFF0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
